matrix_mult_ctrl: RTL and testbench

- Initiator/master for the shared 3-matrix memory's single read/write port (matrix select, row, column, write enable, write data, combinational read data).
- On a start pulse it reads matrix A (slot 0) and matrix B (slot 1), computes C = A x B with unsigned saturating arithmetic, and writes C into slot 2.
- Sits between the top-level control FSM and the memory. The top level muxes this block's port onto the memory while busy is high.

---
 rtl/matrix_mult_ctrl.sv | 170 +++++++++++++++++
 tb/tb_matrix_mult_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_ctrl.sv
// Memory-port master that reads A and B from a shared matrix memory, computes
// C = A x B with unsigned saturating arithmetic and writes C back row-major.
module matrix_mult_ctrl #(
  parameter int         N      = 3,
  parameter int         DATA_W = 8,
  parameter int         ACC_W  = 20,
  parameter logic [1:0] SRC_A  = 2'd0,
  parameter logic [1:0] SRC_B  = 2'd1,
  parameter logic [1:0] DST_C  = 2'd2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              saturated,
  output logic [1:0]        mem_matrix_select,
  output logic [3:0]        mem_row,
  output logic [3:0]        mem_col,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0]       LAST_IDX = 4'(N - 1);
  localparam logic [ACC_W-1:0] ELEM_MAX = ACC_W'((64'd1 << DATA_W) - 64'd1);

  state_t              state_q, state_d;
  logic [3:0]          i_q, i_d;
  logic [3:0]          j_q, j_d;
  logic [3:0]          k_q, k_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   a_latch_q, a_latch_d;
  logic                sat_q, sat_d;
  logic [2*DATA_W-1:0] prod_s;
  logic                clip_s;

  assign prod_s = a_latch_q * mem_read_data;
  assign clip_s = (acc_q > ELEM_MAX);

  // Next-state and datapath update for the multiply sequencer
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    acc_d     = acc_q;
    a_latch_d = a_latch_q;
    sat_d     = sat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_A;
          i_d     = 4'd0;
          j_d     = 4'd0;
          k_d     = 4'd0;
          acc_d   = '0;
          sat_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_A: begin
        a_latch_d = mem_read_data;
        state_d   = S_RD_B;
      end
      S_RD_B: begin
        acc_d = acc_q + ACC_W'(prod_s);
        if (k_q == LAST_IDX) begin
          state_d = S_WRITE;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = S_RD_A;
        end
      end
      S_WRITE: begin
        sat_d = sat_q | clip_s;
        acc_d = '0;
        k_d   = 4'd0;
        if (j_q < LAST_IDX) begin
          j_d     = j_q + 4'd1;
          state_d = S_RD_A;
        end else if (i_q < LAST_IDX) begin
          j_d     = 4'd0;
          i_d     = i_q + 4'd1;
          state_d = S_RD_A;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      i_q       <= 4'd0;
      j_q       <= 4'd0;
      k_q       <= 4'd0;
      acc_q     <= '0;
      a_latch_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      a_latch_q <= a_latch_d;
      sat_q     <= sat_d;
    end
  end

  // Memory port and status decode from the registered state and indices
  always_comb begin
    busy              = 1'b1;
    done              = 1'b0;
    mem_matrix_select = 2'd0;
    mem_row           = 4'd0;
    mem_col           = 4'd0;
    mem_write_enable  = 1'b0;
    mem_write_data    = '0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_RD_A: begin
        mem_matrix_select = SRC_A;
        mem_row           = i_q;
        mem_col           = k_q;
      end
      S_RD_B: begin
        mem_matrix_select = SRC_B;
        mem_row           = k_q;
        mem_col           = j_q;
      end
      S_WRITE: begin
        mem_matrix_select = DST_C;
        mem_row           = i_q;
        mem_col           = j_q;
        mem_write_enable  = 1'b1;
        mem_write_data    = clip_s ? {DATA_W{1'b1}} : acc_q[DATA_W-1:0];
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign saturated = sat_q;

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// Scoreboard bench for matrix_mult_ctrl: a behavioural memory serves reads,
// expected C writes are queued by the stimulus and popped by a write monitor.
module tb_matrix_mult_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, saturated;
  logic [1:0] mem_matrix_select;
  logic [3:0] mem_row, mem_col;
  logic       mem_write_enable;
  logic [7:0] mem_write_data;
  logic [7:0] mem_read_data;

  logic [7:0] mem [0:3][0:9][0:9];

  typedef struct {
    logic [1:0] sel;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  matrix_mult_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .saturated         (saturated),
    .mem_matrix_select (mem_matrix_select),
    .mem_row           (mem_row),
    .mem_col           (mem_col),
    .mem_write_enable  (mem_write_enable),
    .mem_write_data    (mem_write_data),
    .mem_read_data     (mem_read_data)
  );

  assign mem_read_data = mem[mem_matrix_select][mem_row][mem_col];

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_matrix_select][mem_row][mem_col] <= mem_write_data;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Write monitor: every strobe must match the head of the scoreboard queue
  always @(posedge clk) begin
    #1;
    if (mem_write_enable) begin
      chk("we_only_when_working", int'(busy && !done), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {mem_matrix_select, mem_row, mem_col}, {e.sel, e.row, e.col});
        chk("wr_data", int'(mem_write_data), int'(e.data));
      end
    end
  end

  task automatic load(input int slot, input int v[9]);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) mem[slot][r][c] = 8'(v[r*3+c]);
  endtask

  task automatic push_c(input int c[9]);
    for (int n = 0; n < 9; n++) begin
      wr_t e;
      e.sel = 2'd2; e.row = 4'(n / 3); e.col = 4'(n % 3); e.data = 8'(c[n]);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_c(input string name, input int c[9]);
    for (int n = 0; n < 9; n++) chk(name, int'(mem[2][n/3][n%3]), c[n]);
  endtask

  // Start one operation and check latency, done pulse and final status
  task automatic run_op(input string name, input int c[9], input int exp_sat);
    int cyc;
    push_c(c);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_start", int'(busy), 1);
    chk("sat_cleared_on_start", int'(saturated), 0);
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      @(posedge clk); #1; cyc++;
    end
    chk("done_latency", cyc, 64);
    chk("saturated", int'(saturated), exp_sat);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);
    chk("queue_drained", exp_q.size(), 0);
    check_c(name, c);
  endtask

  int ident[9] = '{1,0,0, 0,1,0, 0,0,1};
  int seq19[9] = '{1,2,3, 4,5,6, 7,8,9};
  int twos[9]  = '{2,2,2, 2,2,2, 2,2,2};
  int c12[9]   = '{12,12,12, 12,12,12, 12,12,12};
  int tw20[9]  = '{20,20,20, 20,20,20, 20,20,20};
  int c255[9]  = '{255,255,255, 255,255,255, 255,255,255};
  int a08[9]   = '{0,1,2, 3,4,5, 6,7,8};
  int b80[9]   = '{8,7,6, 5,4,3, 2,1,0};
  int cab[9]   = '{9,6,3, 54,42,30, 99,78,57};

  initial begin
    int cyc, ndone, d1, d2, busy_seen;
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 10; c++) mem[s][r][c] = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sat", int'(saturated), 0);
    chk("rst_mem", {mem_matrix_select, mem_row, mem_col, mem_write_enable, mem_write_data}, 0);
    @(negedge clk); reset = 1'b1;

    load(0, ident); load(1, seq19);
    run_op("c_identity", seq19, 0);

    load(0, twos); load(1, twos);
    run_op("c_twos", c12, 0);

    load(0, tw20); load(1, tw20);
    run_op("c_sat", c255, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_held", int'(saturated), 1);

    load(0, a08); load(1, b80);
    run_op("c_nonuniform", cab, 0);

    // Start held high: a second operation follows the first without a new pulse
    load(0, ident); load(1, seq19);
    push_c(seq19); push_c(seq19);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    cyc = 1; ndone = 0; d1 = 0; d2 = 0;
    while (ndone < 2 && cyc < 400) begin
      if (done) begin
        ndone++;
        if (ndone == 1) d1 = cyc; else begin d2 = cyc; start = 1'b0; end
      end
      if (ndone < 2) begin @(posedge clk); #1; cyc++; end
    end
    chk("held_first_done", d1, 64);
    chk("held_second_done", d2, 129);
    busy_seen = 0;
    repeat (20) begin @(posedge clk); #1; if (busy) busy_seen++; end
    chk("held_no_third_op", busy_seen, 0);
    chk("held_queue_drained", exp_q.size(), 0);

    // Reset after three C elements are written (writes land in cycles 7, 14, 21, 28)
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) mem[2][r][c] = 8'hAA;
    load(0, twos); load(1, twos);
    for (int n = 0; n < 3; n++) begin
      wr_t e;
      e.sel = 2'd2; e.row = 4'd0; e.col = 4'(n); e.data = 8'd12;
      exp_q.push_back(e);
    end
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    @(negedge clk); start = 1'b0;
    while (cyc < 25) begin @(posedge clk); #1; cyc++; end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_mem", {mem_matrix_select, mem_row, mem_col, mem_write_enable, mem_write_data}, 0);
    @(negedge clk); reset = 1'b1;
    ndone = 0;
    repeat (80) begin @(posedge clk); #1; if (done) ndone++; end
    chk("abort_no_done", ndone, 0);
    chk("abort_queue_drained", exp_q.size(), 0);
    for (int n = 0; n < 9; n++)
      chk("abort_c", int'(mem[2][n/3][n%3]), (n < 3) ? 12 : 170);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
